// File: rtl/result_writeback_pkg.sv
// Shared types and constants for the GDDR6 result write-back path.
//   wb_state_t      : write-back FSM encoding (also exported on o_wb_state)
//   wb_burst_beats  : beats in the next burst: the smallest of the lines left,
//                     the burst cap and the lines left before the next 4 KB boundary
package result_writeback_pkg;

  localparam int unsigned link_addr_width_gp = 28;
  localparam int unsigned link_len_width_gp  = 16;
  localparam int unsigned AXI_ID_WIDTH       = 4;

  localparam int unsigned WB_LINE_BYTES      = 32;
  localparam logic [2:0]  WB_AXSIZE          = 3'd5;
  localparam int unsigned WB_4K_LINES        = 128;
  localparam int unsigned WB_4K_LINE_BITS    = $clog2(WB_4K_LINES);
  localparam int unsigned WB_BEATS_WIDTH     = 9;

  localparam logic [1:0]  AXI_BURST_INCR     = 2'b01;
  localparam logic [1:0]  AXI_RESP_OKAY      = 2'b00;

  typedef enum logic [3:0] {
    WB_IDLE,
    WB_ADDR,
    WB_DATA,
    WB_RESP,
    WB_DONE
  } wb_state_t;

  function automatic logic [WB_BEATS_WIDTH-1:0] wb_burst_beats(
    input logic [link_len_width_gp-1:0] remaining,
    input logic [WB_4K_LINE_BITS-1:0]   line_lo,
    input int unsigned                  max_beats
  );
    logic [WB_BEATS_WIDTH-1:0] beats;
    logic [WB_BEATS_WIDTH-1:0] to_4k;
    to_4k = WB_BEATS_WIDTH'(WB_4K_LINES) - WB_BEATS_WIDTH'(line_lo);
    beats = WB_BEATS_WIDTH'(max_beats);
    if (to_4k < beats) beats = to_4k;
    if (remaining < link_len_width_gp'(beats)) beats = WB_BEATS_WIDTH'(remaining);
    return beats;
  endfunction

endpackage

// File: rtl/result_writeback_fifo.sv
// Line FIFO for the write-back path (first-word fall-through).
//   clk_i, rst_ni : clock, async active-low reset (flushes the FIFO)
//   push_i, din_i : write a line; accepted when not full, or when full and popping
//   pop_i         : consume the head line; ignored while empty
//   head_o        : current head line, valid whenever empty_o is low
//   count_o       : number of lines held
//   full_o/empty_o: occupancy flags
module result_wb_fifo #(
  parameter int unsigned WIDTH = 256,
  parameter int unsigned DEPTH = 32
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       push_i,
  input  logic [WIDTH-1:0]           din_i,
  input  logic                       pop_i,
  output logic [WIDTH-1:0]           head_o,
  output logic [$clog2(DEPTH):0]     count_o,
  output logic                       full_o,
  output logic                       empty_o
);

  localparam int unsigned PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q;
  logic [PTR_W-1:0] rd_ptr_q;
  logic [PTR_W:0]   count_q;
  logic             push_eff;
  logic             pop_eff;

  assign empty_o  = (count_q == '0);
  assign full_o   = (count_q == (PTR_W+1)'(DEPTH));
  assign pop_eff  = pop_i && !empty_o;
  assign push_eff = push_i && (!full_o || pop_eff);
  assign count_o  = count_q;
  assign head_o   = mem_q[rd_ptr_q];

  always_ff @(posedge clk_i) begin
    if (push_eff) mem_q[wr_ptr_q] <= din_i;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_eff) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop_eff)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      case ({push_eff, pop_eff})
        2'b10:   count_q <= count_q + (PTR_W+1)'(1);
        2'b01:   count_q <= count_q - (PTR_W+1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/result_writeback.sv
// Result write-back: packs FP16 results into 256-bit lines, buffers them in a
// line FIFO and writes them to GDDR6 as AXI4 INCR bursts (one outstanding).
//   i_clk, i_reset_n        : clock, async active-low reset
//   i_wb_en/addr/len        : start pulse (IDLE only), start line, line count
//   o_wb_done               : one-cycle pulse after the final B response
//   i_result_valid/data,
//   o_result_ready          : result stream, result k of a line at bits [k*16 +: 16]
//   o_axi_aw*/w*/b*         : AXI4 write channels
//   o_axi_ar*/rready, i_axi_r*/arready : read channels, held inactive
//   o_wb_state              : FSM state
//   o_wb_line_count         : lines acknowledged in the current command
//   o_wb_err                : sticky non-OKAY bresp, cleared by an accepted start
// Optional: RESULT_WB_PERF_CNT_EN adds o_wb_cycles (start..done, inclusive).
module result_writeback
  import result_writeback_pkg::*;
#(
  parameter int unsigned DATA_WIDTH     = 256,
  parameter int unsigned RESULT_WIDTH   = 16,
  parameter int unsigned AXI_ADDR_WIDTH = 42,
  parameter int unsigned BURST_LEN      = 16,
  parameter int unsigned FIFO_DEPTH     = 32,
  parameter logic [8:0]  GDDR6_PAGE_ID  = 9'd2
) (
  input  logic                          i_clk,
  input  logic                          i_reset_n,
  input  logic                          i_wb_en,
  input  logic [link_addr_width_gp-1:0] i_wb_addr,
  input  logic [link_len_width_gp-1:0]  i_wb_len,
  output logic                          o_wb_done,
  input  logic                          i_result_valid,
  input  logic [RESULT_WIDTH-1:0]       i_result_data,
  output logic                          o_result_ready,
  output logic [AXI_ID_WIDTH-1:0]       o_axi_awid,
  output logic [AXI_ADDR_WIDTH-1:0]     o_axi_awaddr,
  output logic [7:0]                    o_axi_awlen,
  output logic [2:0]                    o_axi_awsize,
  output logic [1:0]                    o_axi_awburst,
  output logic                          o_axi_awvalid,
  input  logic                          i_axi_awready,
  output logic [DATA_WIDTH-1:0]         o_axi_wdata,
  output logic [DATA_WIDTH/8-1:0]       o_axi_wstrb,
  output logic                          o_axi_wlast,
  output logic                          o_axi_wvalid,
  input  logic                          i_axi_wready,
  input  logic [1:0]                    i_axi_bresp,
  input  logic                          i_axi_bvalid,
  output logic                          o_axi_bready,
  output logic [AXI_ID_WIDTH-1:0]       o_axi_arid,
  output logic [AXI_ADDR_WIDTH-1:0]     o_axi_araddr,
  output logic [7:0]                    o_axi_arlen,
  output logic [2:0]                    o_axi_arsize,
  output logic [1:0]                    o_axi_arburst,
  output logic                          o_axi_arvalid,
  input  logic                          i_axi_arready,
  input  logic [DATA_WIDTH-1:0]         i_axi_rdata,
  input  logic [1:0]                    i_axi_rresp,
  input  logic                          i_axi_rlast,
  input  logic                          i_axi_rvalid,
  output logic                          o_axi_rready,
  output logic [3:0]                    o_wb_state,
  output logic [15:0]                   o_wb_line_count,
  output logic                          o_wb_err
`ifdef RESULT_WB_PERF_CNT_EN
  ,
  output logic [31:0]                   o_wb_cycles
`endif
);

  localparam int unsigned RPL    = DATA_WIDTH / RESULT_WIDTH;
  localparam int unsigned SLOT_W = $clog2(RPL);
  localparam int unsigned PKD_W  = link_len_width_gp + SLOT_W;
  localparam int unsigned CNT_W  = $clog2(FIFO_DEPTH) + 1;
  localparam int unsigned OFS_W  = $clog2(WB_LINE_BYTES);
  localparam int unsigned BW     = WB_BEATS_WIDTH;
  localparam int unsigned LA     = link_addr_width_gp;
  localparam int unsigned LL     = link_len_width_gp;

  wb_state_t          state_q, state_d;
  logic [LA-1:0]      line_addr_q, line_addr_d;
  logic [LL-1:0]      remaining_q, remaining_d;
  logic [LL-1:0]      len_q, len_d;
  logic [LL-1:0]      line_count_q, line_count_d;
  logic [BW-1:0]      burst_q, burst_d;
  logic [BW-1:0]      beat_q, beat_d;
  logic               err_q, err_d;

  logic [PKD_W-1:0]      packed_q, packed_d;
  logic [SLOT_W-1:0]     slot_q, slot_d;
  logic [DATA_WIDTH-1:0] line_q, line_d;

  logic                  fifo_push;
  logic                  fifo_pop;
  logic [DATA_WIDTH-1:0] fifo_head;
  logic [CNT_W-1:0]      fifo_count;
  logic                  fifo_full;
  logic                  fifo_empty;

  logic [BW-1:0]    beats_c;
  logic             start;
  logic             running;
  logic             res_fire;
  logic [PKD_W-1:0] total_results;

  result_wb_fifo #(
    .WIDTH (DATA_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (i_clk),
    .rst_ni  (i_reset_n),
    .push_i  (fifo_push),
    .din_i   (line_d),
    .pop_i   (fifo_pop),
    .head_o  (fifo_head),
    .count_o (fifo_count),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  assign beats_c       = wb_burst_beats(remaining_q, line_addr_q[WB_4K_LINE_BITS-1:0], BURST_LEN);
  assign start         = (state_q == WB_IDLE) && i_wb_en;
  assign running       = (state_q == WB_ADDR) || (state_q == WB_DATA) || (state_q == WB_RESP);
  assign total_results = PKD_W'(len_q) << SLOT_W;
  // Full FIFO stalls the stream even mid-line so the 16th result always has a slot.
  assign o_result_ready = running && !fifo_full && (packed_q < total_results);
  assign res_fire       = i_result_valid && o_result_ready;
  assign fifo_pop       = o_axi_wvalid && i_axi_wready;

  // Static AXI fields and the inactive read side.
  assign o_axi_awid    = '0;
  assign o_axi_awaddr  = AXI_ADDR_WIDTH'({GDDR6_PAGE_ID, line_addr_q, OFS_W'(0)});
  assign o_axi_awlen   = 8'(beats_c - BW'(1));
  assign o_axi_awsize  = WB_AXSIZE;
  assign o_axi_awburst = AXI_BURST_INCR;
  assign o_axi_wdata   = fifo_head;
  assign o_axi_wstrb   = '1;
  assign o_axi_arid    = '0;
  assign o_axi_araddr  = '0;
  assign o_axi_arlen   = '0;
  assign o_axi_arsize  = '0;
  assign o_axi_arburst = '0;
  assign o_axi_arvalid = 1'b0;
  assign o_axi_rready  = 1'b1;

  logic unused_axi_r;
  assign unused_axi_r = ^{i_axi_arready, i_axi_rdata, i_axi_rresp, i_axi_rlast, i_axi_rvalid};

  assign o_wb_state      = state_q;
  assign o_wb_line_count = 16'(line_count_q);
  assign o_wb_err        = err_q;

  // Packer: the pushed line is line_d, so the 16th result enters the FIFO
  // on the same edge it is accepted.
  always_comb begin
    packed_d  = packed_q;
    slot_d    = slot_q;
    line_d    = line_q;
    fifo_push = 1'b0;
    if (start) begin
      packed_d = '0;
      slot_d   = '0;
    end else if (res_fire) begin
      line_d[slot_q*RESULT_WIDTH +: RESULT_WIDTH] = i_result_data;
      packed_d = packed_q + PKD_W'(1);
      if (slot_q == SLOT_W'(RPL - 1)) begin
        fifo_push = 1'b1;
        slot_d    = '0;
      end else begin
        slot_d = slot_q + SLOT_W'(1);
      end
    end
  end

  always_comb begin
    state_d       = state_q;
    line_addr_d   = line_addr_q;
    remaining_d   = remaining_q;
    len_d         = len_q;
    line_count_d  = line_count_q;
    burst_d       = burst_q;
    beat_d        = beat_q;
    err_d         = err_q;
    o_axi_awvalid = 1'b0;
    o_axi_wvalid  = 1'b0;
    o_axi_wlast   = 1'b0;
    o_axi_bready  = 1'b0;
    o_wb_done     = 1'b0;
    case (state_q)
      WB_IDLE: begin
        if (i_wb_en) begin
          len_d        = i_wb_len;
          line_addr_d  = i_wb_addr;
          remaining_d  = i_wb_len;
          line_count_d = '0;
          err_d        = 1'b0;
          state_d      = (i_wb_len == '0) ? WB_DONE : WB_ADDR;
        end
      end
      WB_ADDR: begin
        // Whole burst buffered before AW, so W never stalls on the stream.
        o_axi_awvalid = (BW'(fifo_count) >= beats_c);
        if (o_axi_awvalid && i_axi_awready) begin
          burst_d     = beats_c;
          beat_d      = '0;
          line_addr_d = line_addr_q + LA'(beats_c);
          remaining_d = remaining_q - LL'(beats_c);
          state_d     = WB_DATA;
        end
      end
      WB_DATA: begin
        o_axi_wvalid = !fifo_empty;
        o_axi_wlast  = (beat_q == burst_q - BW'(1));
        if (o_axi_wvalid && i_axi_wready) begin
          beat_d = beat_q + BW'(1);
          if (o_axi_wlast) state_d = WB_RESP;
        end
      end
      WB_RESP: begin
        o_axi_bready = 1'b1;
        if (i_axi_bvalid) begin
          line_count_d = line_count_q + LL'(burst_q);
          err_d        = err_q | (i_axi_bresp != AXI_RESP_OKAY);
          state_d      = (remaining_q == '0) ? WB_DONE : WB_ADDR;
        end
      end
      WB_DONE: begin
        o_wb_done = 1'b1;
        state_d   = WB_IDLE;
      end
      default: state_d = WB_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q      <= WB_IDLE;
      line_addr_q  <= '0;
      remaining_q  <= '0;
      len_q        <= '0;
      line_count_q <= '0;
      burst_q      <= '0;
      beat_q       <= '0;
      err_q        <= 1'b0;
      packed_q     <= '0;
      slot_q       <= '0;
      line_q       <= '0;
    end else begin
      state_q      <= state_d;
      line_addr_q  <= line_addr_d;
      remaining_q  <= remaining_d;
      len_q        <= len_d;
      line_count_q <= line_count_d;
      burst_q      <= burst_d;
      beat_q       <= beat_d;
      err_q        <= err_d;
      packed_q     <= packed_d;
      slot_q       <= slot_d;
      line_q       <= line_d;
    end
  end

`ifdef RESULT_WB_PERF_CNT_EN
  logic [31:0] cycles_q;
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n)              cycles_q <= '0;
    else if (start)              cycles_q <= 32'd1;
    else if (state_q != WB_IDLE) cycles_q <= cycles_q + 32'd1;
  end
  assign o_wb_cycles = cycles_q;
`endif

endmodule

// File: tb/tb_result_writeback.sv
module tb_result_writeback;
  import result_writeback_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic         i_wb_en = 1'b0;
  logic [27:0]  i_wb_addr = '0;
  logic [15:0]  i_wb_len = '0;
  logic         o_wb_done;
  logic         i_result_valid = 1'b0;
  logic [15:0]  i_result_data = '0;
  logic         o_result_ready;
  logic [3:0]   o_axi_awid;
  logic [41:0]  o_axi_awaddr;
  logic [7:0]   o_axi_awlen;
  logic [2:0]   o_axi_awsize;
  logic [1:0]   o_axi_awburst;
  logic         o_axi_awvalid;
  logic         i_axi_awready = 1'b0;
  logic [255:0] o_axi_wdata;
  logic [31:0]  o_axi_wstrb;
  logic         o_axi_wlast;
  logic         o_axi_wvalid;
  logic         i_axi_wready = 1'b0;
  logic [1:0]   i_axi_bresp = '0;
  logic         i_axi_bvalid = 1'b0;
  logic         o_axi_bready;
  logic [3:0]   o_axi_arid;
  logic [41:0]  o_axi_araddr;
  logic [7:0]   o_axi_arlen;
  logic [2:0]   o_axi_arsize;
  logic [1:0]   o_axi_arburst;
  logic         o_axi_arvalid;
  logic         o_axi_rready;
  logic [3:0]   o_wb_state;
  logic [15:0]  o_wb_line_count;
  logic         o_wb_err;
`ifdef RESULT_WB_PERF_CNT_EN
  logic [31:0]  o_wb_cycles;
`endif

  result_writeback #(
    .DATA_WIDTH(256), .RESULT_WIDTH(16), .AXI_ADDR_WIDTH(42),
    .BURST_LEN(16), .FIFO_DEPTH(32), .GDDR6_PAGE_ID(9'd2)
  ) dut (
    .i_clk(clk), .i_reset_n(rst_n),
    .i_wb_en(i_wb_en), .i_wb_addr(i_wb_addr), .i_wb_len(i_wb_len), .o_wb_done(o_wb_done),
    .i_result_valid(i_result_valid), .i_result_data(i_result_data), .o_result_ready(o_result_ready),
    .o_axi_awid(o_axi_awid), .o_axi_awaddr(o_axi_awaddr), .o_axi_awlen(o_axi_awlen),
    .o_axi_awsize(o_axi_awsize), .o_axi_awburst(o_axi_awburst), .o_axi_awvalid(o_axi_awvalid),
    .i_axi_awready(i_axi_awready),
    .o_axi_wdata(o_axi_wdata), .o_axi_wstrb(o_axi_wstrb), .o_axi_wlast(o_axi_wlast),
    .o_axi_wvalid(o_axi_wvalid), .i_axi_wready(i_axi_wready),
    .i_axi_bresp(i_axi_bresp), .i_axi_bvalid(i_axi_bvalid), .o_axi_bready(o_axi_bready),
    .o_axi_arid(o_axi_arid), .o_axi_araddr(o_axi_araddr), .o_axi_arlen(o_axi_arlen),
    .o_axi_arsize(o_axi_arsize), .o_axi_arburst(o_axi_arburst), .o_axi_arvalid(o_axi_arvalid),
    .i_axi_arready(1'b0), .i_axi_rdata('0), .i_axi_rresp(2'b00), .i_axi_rlast(1'b0),
    .i_axi_rvalid(1'b0), .o_axi_rready(o_axi_rready),
    .o_wb_state(o_wb_state), .o_wb_line_count(o_wb_line_count), .o_wb_err(o_wb_err)
`ifdef RESULT_WB_PERF_CNT_EN
    , .o_wb_cycles(o_wb_cycles)
`endif
  );

  typedef struct { logic [41:0] addr; logic [7:0] len; } aw_t;
  typedef struct { logic [255:0] data; bit last; } w_t;
  typedef struct { logic [15:0] lines; bit err; } done_t;

  aw_t   exp_aw[$];
  w_t    exp_w[$];
  done_t exp_done[$];
  logic [15:0] res_q[$];

  int checks = 0;
  int errors = 0;
  int done_cnt = 0;
  int unsigned res_accepted = 0;
  int b_owed = 0;
  bit res_fire_pend = 0, w_last_pend = 0, b_fire_pend = 0;
  bit fast_mode = 1, w_block = 0;
  logic [1:0] bresp_cfg = 2'b00;

  task automatic check(input bit ok, input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Slave / stream agent and scoreboard monitor: everything decided on the
  // falling edge; a handshake seen here completes on the next rising edge.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        res_fire_pend = 0; w_last_pend = 0; b_fire_pend = 0; b_owed = 0;
        i_result_valid = 0; i_axi_awready = 0; i_axi_wready = 0; i_axi_bvalid = 0;
      end else begin
        if (res_fire_pend) begin
          void'(res_q.pop_front());
          res_accepted++;
          res_fire_pend = 0;
        end
        i_result_valid = (res_q.size() > 0) && (fast_mode || $urandom_range(1) == 1);
        i_result_data  = (res_q.size() > 0) ? res_q[0] : 16'h0;
        if (i_result_valid && o_result_ready) res_fire_pend = 1;

        i_axi_awready = fast_mode || ($urandom_range(3) != 0);
        if (o_axi_awvalid && i_axi_awready) begin
          if (exp_aw.size() == 0) check(0, "aw_unexpected", {o_axi_awaddr, o_axi_awlen}, 0);
          else begin
            aw_t e;
            e = exp_aw.pop_front();
            check({o_axi_awid, o_axi_awaddr, o_axi_awlen, o_axi_awsize, o_axi_awburst} ==
                  {4'd0, e.addr, e.len, 3'd5, 2'b01}, "aw_fields",
                  {o_axi_awid, o_axi_awaddr, o_axi_awlen, o_axi_awsize, o_axi_awburst},
                  {4'd0, e.addr, e.len, 3'd5, 2'b01});
          end
        end

        if (w_last_pend) begin b_owed++; w_last_pend = 0; end
        i_axi_wready = !w_block && (fast_mode || ($urandom_range(3) != 0));
        if (o_axi_wvalid && i_axi_wready) begin
          if (exp_w.size() == 0) check(0, "w_unexpected", o_axi_wdata, 0);
          else begin
            w_t e;
            e = exp_w.pop_front();
            check(o_axi_wdata == e.data, "w_data", o_axi_wdata, e.data);
            check({o_axi_wlast, o_axi_wstrb} == {e.last, 32'hFFFF_FFFF}, "w_last_strb",
                  {o_axi_wlast, o_axi_wstrb}, {e.last, 32'hFFFF_FFFF});
          end
          if (o_axi_wlast) w_last_pend = 1;
        end

        if (b_fire_pend) begin i_axi_bvalid = 0; b_owed--; b_fire_pend = 0; end
        if (!i_axi_bvalid && b_owed > 0 && (fast_mode || $urandom_range(2) == 0)) begin
          i_axi_bvalid = 1;
          i_axi_bresp  = bresp_cfg;
        end
        if (i_axi_bvalid && o_axi_bready) b_fire_pend = 1;

        if (o_wb_done) begin
          done_cnt++;
          if (exp_done.size() == 0) check(0, "done_unexpected", 1, 0);
          else begin
            done_t e;
            e = exp_done.pop_front();
            check({o_wb_line_count, o_wb_err} == {e.lines, e.err}, "done_count_err",
                  {o_wb_line_count, o_wb_err}, {e.lines, e.err});
          end
        end
      end
    end
  end

  // Reference model: results in arrival order, 16 per line, lines written in
  // order as bursts capped at 16 beats and at the 128-line (4 KB) boundary.
  task automatic model_cmd(input logic [27:0] addr, input int len, input logic [1:0] bresp,
                           input bit seq, input int extra);
    logic [15:0] r[$];
    logic [255:0] data;
    int unsigned cur;
    int rem, b, ln;
    for (int i = 0; i < len * 16; i++) r.push_back(seq ? 16'(i + 1) : 16'($urandom));
    cur = addr; rem = len; ln = 0;
    while (rem > 0) begin
      b = rem;
      if (b > 16) b = 16;
      if (b > 128 - int'(cur % 128)) b = 128 - int'(cur % 128);
      exp_aw.push_back('{{9'd2, 28'(cur), 5'd0}, 8'(b - 1)});
      for (int j = 0; j < b; j++) begin
        data = '0;
        for (int k = 0; k < 16; k++) data[k*16 +: 16] = r[ln*16 + k];
        exp_w.push_back('{data, j == b - 1});
        ln++;
      end
      cur += b; rem -= b;
    end
    exp_done.push_back('{16'(len), (bresp != 2'b00) && (len != 0)});
    foreach (r[i]) res_q.push_back(r[i]);
    for (int i = 0; i < extra; i++) res_q.push_back(16'($urandom));
    res_accepted = 0;
    bresp_cfg = bresp;
  endtask

  task automatic run_cmd(input logic [27:0] addr, input int len, input bit fast,
                         input logic [1:0] bresp, input bit seq, input int extra);
    int d0;
    fast_mode = fast;
    model_cmd(addr, len, bresp, seq, extra);
    d0 = done_cnt;
    @(negedge clk);
    i_wb_en = 1; i_wb_addr = addr; i_wb_len = 16'(len);
    @(negedge clk);
    i_wb_en = 0;
    check(o_wb_err == 1'b0, "err_cleared_on_start", o_wb_err, 0);
    if (len == 0) begin
      check({o_wb_done, o_axi_awvalid} == 2'b10, "len0_done_next_cycle", {o_wb_done, o_axi_awvalid}, 2'b10);
    end
    for (int c = 0; c < 20000 && done_cnt == d0; c++) @(negedge clk);
    check(done_cnt == d0 + 1, "done_within_budget", done_cnt, d0 + 1);
    repeat (3) @(negedge clk);
    check(done_cnt == d0 + 1, "single_done_pulse", done_cnt, d0 + 1);
    check(o_wb_err == ((bresp != 2'b00) && (len != 0)), "err_sticky", o_wb_err, (bresp != 2'b00) && (len != 0));
    check(o_wb_line_count == 16'(len), "line_count_hold", o_wb_line_count, len);
    check(exp_aw.size() == 0 && exp_w.size() == 0, "all_bursts_written", exp_aw.size() + exp_w.size(), 0);
    check(res_accepted == 32'(len * 16), "results_accepted", res_accepted, len * 16);
    check(res_q.size() == extra, "extra_results_refused", res_q.size(), extra);
    res_q.delete();
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check({o_axi_awvalid, o_axi_wvalid, o_axi_bready, o_result_ready, o_wb_done, o_wb_err,
           o_wb_state, o_wb_line_count} == '0, "reset_outputs",
          {o_axi_awvalid, o_axi_wvalid, o_axi_bready, o_result_ready, o_wb_done, o_wb_err,
           o_wb_state, o_wb_line_count}, 0);
    rst_n = 1;
    repeat (2) @(negedge clk);

    run_cmd(28'd0,   1,  1, 2'b00, 1, 0);
    run_cmd(28'd0,   40, 1, 2'b00, 0, 0);
    run_cmd(28'd120, 20, 1, 2'b00, 0, 0);
    run_cmd(28'd5,   4,  1, 2'b10, 0, 0);
    run_cmd(28'd7,   2,  1, 2'b00, 0, 0);
    run_cmd(28'd0,   4,  0, 2'b00, 0, 16);
    for (int t = 0; t < 4; t++)
      run_cmd(28'($urandom_range(0, 300)), $urandom_range(1, 40), 0, 2'b00, 0, 8);
    run_cmd(28'd10, 0, 1, 2'b00, 0, 0);
`ifdef RESULT_WB_PERF_CNT_EN
    check(o_wb_cycles == 32'd2, "perf_cycles_len0", o_wb_cycles, 2);
`endif

    // Reset while the DUT is in the data phase of a burst.
    fast_mode = 1; w_block = 1;
    model_cmd(28'd0, 16, 2'b00, 0, 0);
    @(negedge clk);
    i_wb_en = 1; i_wb_addr = 28'd0; i_wb_len = 16'd16;
    @(negedge clk);
    i_wb_en = 0;
    for (int c = 0; c < 500 && !o_axi_wvalid; c++) @(negedge clk);
    check(o_axi_wvalid == 1'b1, "reached_data_phase", o_axi_wvalid, 1);
    @(posedge clk);
    #2 rst_n = 0;
    #1 check({o_axi_awvalid, o_axi_wvalid, o_axi_bready, o_result_ready, o_wb_done, o_wb_state} == '0,
             "reset_mid_burst", {o_axi_awvalid, o_axi_wvalid, o_axi_bready, o_result_ready, o_wb_done, o_wb_state}, 0);
    exp_aw.delete(); exp_w.delete(); exp_done.delete(); res_q.delete();
    w_block = 0;
    repeat (3) @(negedge clk);
    rst_n = 1;
    repeat (2) @(negedge clk);
    run_cmd(28'd3, 2, 1, 2'b00, 0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
